cond_eval_unit: RTL and testbench

//  Next-generation ARM condition unit: owns the NZCV status register and evaluates

---
 rtl/cond_eval_unit.sv | 164 ++++++++++++++++
 tb/tb_cond_eval_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_eval_unit.sv
// NZCV status register plus a registered per-lane ARM condition evaluator.
// Optional statistics counters are built when COND_STATS_EN is defined.
module cond_eval_unit #(
    parameter int LANES  = 1,
    parameter bit BYPASS = 1'b1
`ifdef COND_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 status_we_i,
    input  logic [3:0]           status_mask_i,
    input  logic [3:0]           status_in_i,
    input  logic [LANES-1:0]     in_valid_i,
    input  logic [4*LANES-1:0]   cond_in_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    output logic [LANES-1:0]     out_valid_o,
    output logic [LANES-1:0]     cond_pass_o,
    output logic [3:0]           status_reg_o
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0]     pass_cnt_o,
    output logic [CNT_W-1:0]     fail_cnt_o
`endif
);

    logic [3:0]       status_q;
    logic [3:0]       status_d;
    logic [3:0]       eval_flags_s;
    logic [LANES-1:0] out_valid_q;
    logic [LANES-1:0] out_valid_d;
    logic [LANES-1:0] cond_pass_q;
    logic [LANES-1:0] cond_pass_d;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            4'h0:    cond_eval = z;
            4'h1:    cond_eval = !z;
            4'h2:    cond_eval = c;
            4'h3:    cond_eval = !c;
            4'h4:    cond_eval = n;
            4'h5:    cond_eval = !n;
            4'h6:    cond_eval = v;
            4'h7:    cond_eval = !v;
            4'h8:    cond_eval = c & !z;
            4'h9:    cond_eval = !c | z;
            4'hA:    cond_eval = (n == v);
            4'hB:    cond_eval = (n != v);
            4'hC:    cond_eval = !z & (n == v);
            4'hD:    cond_eval = z | (n != v);
            4'hE:    cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    // Masked flag merge; the status register ignores stall and flush.
    always_comb begin
        status_d = status_q;
        if (status_we_i) begin
            status_d = (status_in_i & status_mask_i) | (status_q & ~status_mask_i);
        end else begin
            status_d = status_q;
        end
    end

    assign eval_flags_s = BYPASS ? status_d : status_q;

    // Output stage next state: flush beats stall beats load.
    always_comb begin
        out_valid_d = out_valid_q;
        cond_pass_d = cond_pass_q;
        if (flush_i) begin
            out_valid_d = '0;
            cond_pass_d = '0;
        end else if (stall_i) begin
            out_valid_d = out_valid_q;
            cond_pass_d = cond_pass_q;
        end else begin
            out_valid_d = in_valid_i;
            for (int i = 0; i < LANES; i++) begin
                cond_pass_d[i] = in_valid_i[i] & cond_eval(cond_in_i[4*i +: 4], eval_flags_s);
            end
        end
    end

    // Status and output-stage registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            status_q    <= 4'b0000;
            out_valid_q <= '0;
            cond_pass_q <= '0;
        end else begin
            status_q    <= status_d;
            out_valid_q <= out_valid_d;
            cond_pass_q <= cond_pass_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign cond_pass_o  = cond_pass_q;
    assign status_reg_o = status_q;

`ifdef COND_STATS_EN
    logic [CNT_W-1:0] pass_cnt_q;
    logic [CNT_W-1:0] pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q;
    logic [CNT_W-1:0] fail_cnt_d;

    function automatic logic [2:0] popcount(input logic [LANES-1:0] vec);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < LANES; i++) begin
            cnt = cnt + {2'b00, vec[i]};
        end
        return cnt;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        if (sum[CNT_W]) begin
            return '1;
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    // Counters advance only on cycles where the output stage loads.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (!flush_i && !stall_i) begin
            pass_cnt_d = sat_add(pass_cnt_q, popcount(in_valid_i & cond_pass_d));
            fail_cnt_d = sat_add(fail_cnt_q, popcount(in_valid_i & ~cond_pass_d));
        end else begin
            pass_cnt_d = pass_cnt_q;
            fail_cnt_d = fail_cnt_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign pass_cnt_o = pass_cnt_q;
    assign fail_cnt_o = fail_cnt_q;
`endif

endmodule

// File: tb/tb_cond_eval_unit.sv
// Self-checking bench for cond_eval_unit: a 2-lane bypassing instance and a
// 1-lane non-bypassing instance share stimulus and are compared to a model.
module tb_cond_eval_unit;

    localparam int MAXC = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       status_we;
    logic [3:0] status_mask;
    logic [3:0] status_in;
    logic [1:0] in_valid;
    logic [7:0] cond_in;
    logic       stall;
    logic       flush;

    logic [1:0] a_valid, a_pass;
    logic [3:0] a_status;
    logic [0:0] b_valid, b_pass;
    logic [3:0] b_status;
`ifdef COND_STATS_EN
    logic [3:0] a_pcnt, a_fcnt, b_pcnt, b_fcnt;
`endif

    int checks   = 0;
    int failures = 0;

    // model state
    logic [3:0] m_flags;
    logic [1:0] m_a_valid, m_a_pass;
    logic       m_b_valid, m_b_pass;
    int         m_a_pcnt, m_a_fcnt, m_b_pcnt, m_b_fcnt;

    always #5 clk = ~clk;

    cond_eval_unit #(.LANES(2), .BYPASS(1'b1)
`ifdef COND_STATS_EN
        , .CNT_W(4)
`endif
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .status_we_i(status_we), .status_mask_i(status_mask),
        .status_in_i(status_in), .in_valid_i(in_valid), .cond_in_i(cond_in),
        .stall_i(stall), .flush_i(flush), .out_valid_o(a_valid), .cond_pass_o(a_pass),
        .status_reg_o(a_status)
`ifdef COND_STATS_EN
        , .pass_cnt_o(a_pcnt), .fail_cnt_o(a_fcnt)
`endif
    );

    cond_eval_unit #(.LANES(1), .BYPASS(1'b0)
`ifdef COND_STATS_EN
        , .CNT_W(4)
`endif
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .status_we_i(status_we), .status_mask_i(status_mask),
        .status_in_i(status_in), .in_valid_i(in_valid[0:0]), .cond_in_i(cond_in[3:0]),
        .stall_i(stall), .flush_i(flush), .out_valid_o(b_valid), .cond_pass_o(b_pass),
        .status_reg_o(b_status)
`ifdef COND_STATS_EN
        , .pass_cnt_o(b_pcnt), .fail_cnt_o(b_fcnt)
`endif
    );

    // Grouped ARM-style decode: pairs of codes share a base test, odd code inverts it.
    function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return cond[0] ? !base : base;
    endfunction

    function automatic int sat(input int x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] nf;
        int np, nfl;
        if (rst) begin
            m_flags = 4'h0; m_a_valid = 2'b00; m_a_pass = 2'b00;
            m_b_valid = 1'b0; m_b_pass = 1'b0;
            m_a_pcnt = 0; m_a_fcnt = 0; m_b_pcnt = 0; m_b_fcnt = 0;
        end else begin
            nf = status_we ? ((status_in & status_mask) | (m_flags & ~status_mask)) : m_flags;
            if (flush) begin
                m_a_valid = 2'b00; m_a_pass = 2'b00; m_b_valid = 1'b0; m_b_pass = 1'b0;
            end else if (!stall) begin
                m_a_valid = in_valid;
                np = 0; nfl = 0;
                for (int i = 0; i < 2; i++) begin
                    m_a_pass[i] = in_valid[i] && ref_pass(cond_in[4*i +: 4], nf);
                    if (in_valid[i]) begin
                        if (m_a_pass[i]) np++; else nfl++;
                    end
                end
                m_a_pcnt = sat(m_a_pcnt + np);
                m_a_fcnt = sat(m_a_fcnt + nfl);
                m_b_valid = in_valid[0];
                m_b_pass  = in_valid[0] && ref_pass(cond_in[3:0], m_flags);
                if (in_valid[0]) begin
                    if (m_b_pass) m_b_pcnt = sat(m_b_pcnt + 1); else m_b_fcnt = sat(m_b_fcnt + 1);
                end
            end
            m_flags = nf;
        end
    endtask

    task automatic compare_all();
        chk("a_out_valid", 32'(a_valid), 32'(m_a_valid));
        chk("a_cond_pass", 32'(a_pass), 32'(m_a_pass));
        chk("a_status", 32'(a_status), 32'(m_flags));
        chk("b_out_valid", 32'(b_valid), 32'(m_b_valid));
        chk("b_cond_pass", 32'(b_pass), 32'(m_b_pass));
        chk("b_status", 32'(b_status), 32'(m_flags));
`ifdef COND_STATS_EN
        chk("a_pass_cnt", 32'(a_pcnt), 32'(m_a_pcnt));
        chk("a_fail_cnt", 32'(a_fcnt), 32'(m_a_fcnt));
        chk("b_pass_cnt", 32'(b_pcnt), 32'(m_b_pcnt));
        chk("b_fail_cnt", 32'(b_fcnt), 32'(m_b_fcnt));
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        rst = 1'b0; status_we = 1'b0; status_mask = 4'h0; status_in = 4'h0;
        in_valid = 2'b00; cond_in = 8'h00; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic set_flags(input logic [3:0] f);
        idle_inputs();
        status_we = 1'b1; status_mask = 4'hF; status_in = f;
        tick();
        status_we = 1'b0;
    endtask

    typedef struct {
        logic [3:0] nzcv;
        logic [3:0] cond;
        logic       exp;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{4'b0010, 4'h8, 1'b1};
        vecs[1]  = '{4'b0110, 4'h8, 1'b0};
        vecs[2]  = '{4'b1111, 4'hF, 1'b0};
        vecs[3]  = '{4'b0100, 4'h0, 1'b1};
        vecs[4]  = '{4'b0000, 4'h1, 1'b1};
        vecs[5]  = '{4'b1001, 4'hA, 1'b1};
        vecs[6]  = '{4'b1000, 4'hB, 1'b1};
        vecs[7]  = '{4'b0000, 4'hC, 1'b1};
        vecs[8]  = '{4'b0100, 4'hD, 1'b1};
        vecs[9]  = '{4'b1111, 4'hE, 1'b1};
        vecs[10] = '{4'b0010, 4'h9, 1'b0};
        vecs[11] = '{4'b0001, 4'h6, 1'b1};
        vecs[12] = '{4'b1000, 4'h5, 1'b0};
        vecs[13] = '{4'b0000, 4'h3, 1'b1};

        // Reset with live inputs
        idle_inputs();
        rst = 1'b1; in_valid = 2'b11; cond_in = 8'hEE;
        status_we = 1'b1; status_mask = 4'hF; status_in = 4'hF;
        tick();
        tick();
        chk("reset_out_valid", 32'(a_valid), 32'd0);
        chk("reset_cond_pass", 32'(a_pass), 32'd0);
        chk("reset_status", 32'(a_status), 32'd0);
        idle_inputs();

        // Decode table vectors
        foreach (vecs[k]) begin
            set_flags(vecs[k].nzcv);
            in_valid = 2'b01; cond_in = {4'h0, vecs[k].cond};
            tick();
            chk($sformatf("vec%0d_a", k), 32'(a_pass[0]), 32'(vecs[k].exp));
            chk($sformatf("vec%0d_b", k), 32'(b_pass[0]), 32'(vecs[k].exp));
        end

        // Full sweep against the model
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                in_valid = 2'b11; cond_in = {4'(15 - c), 4'(c)};
                tick();
            end
        end

        // Masked write
        set_flags(4'b1111);
        status_we = 1'b1; status_mask = 4'b1100; status_in = 4'b0000;
        tick();
        chk("mask_status", 32'(a_status), 32'b0011);
        status_we = 1'b0;

        // Same-cycle bypass
        set_flags(4'b0000);
        status_we = 1'b1; status_mask = 4'hF; status_in = 4'b0100;
        in_valid = 2'b01; cond_in = 8'h00;
        tick();
        chk("bypass_on", 32'(a_pass[0]), 32'd1);
        chk("bypass_off", 32'(b_pass[0]), 32'd0);

        // Stall holds, flush wins over stall, status still written
        idle_inputs();
        in_valid = 2'b11; cond_in = 8'hEE;
        tick();
        chk("load_pass", 32'(a_pass), 32'b11);
        stall = 1'b1; cond_in = 8'hFF;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("stall_hold_pass", 32'(a_pass), 32'b11);
            chk("stall_hold_valid", 32'(a_valid), 32'b11);
        end
        flush = 1'b1; status_we = 1'b1; status_mask = 4'hF; status_in = 4'b1010;
        tick();
        chk("flush_valid", 32'(a_valid), 32'd0);
        chk("flush_pass", 32'(a_pass), 32'd0);
        chk("flush_status", 32'(a_status), 32'b1010);

`ifdef COND_STATS_EN
        // Counters saturate and ignore stalled cycles
        idle_inputs(); rst = 1'b1; tick();
        idle_inputs(); in_valid = 2'b11; cond_in = 8'hEE;
        for (int s = 0; s < 3; s++) tick();
        stall = 1'b1;
        tick(); tick();
        chk("stats_stall_pass", 32'(a_pcnt), 32'd6);
        stall = 1'b0;
        for (int s = 0; s < 5; s++) tick();
        chk("stats_sat_pass", 32'(a_pcnt), 32'hF);
        chk("stats_sat_fail", 32'(a_fcnt), 32'd0);
`endif

        // Randomised traffic including mid-stream resets
        for (int r = 0; r < 600; r++) begin
            rst         = ($urandom_range(0, 59) == 0);
            status_we   = 1'($urandom);
            status_mask = 4'($urandom);
            status_in   = 4'($urandom);
            in_valid    = 2'($urandom);
            cond_in     = 8'($urandom);
            stall       = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
